// File: rtl/afe_config.sv
// rtl/afe_config.sv - AFE register writer over a 3-wire serial port, gates scan_en on AFE being current
module afe_config #(
  parameter int unsigned CLK_DIV   = 5,
  parameter logic [2:0]  CFG_ADDR  = 3'd0,
  parameter logic [8:0]  CFG_DATA  = 9'h0C8,
  parameter logic [2:0]  GAIN_ADDR = 3'd2,
  parameter logic [2:0]  OFF_ADDR  = 3'd5
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        cont_en,
  input  logic [15:0] cont_gain,
  input  logic [15:0] cont_off,
  output logic        afe_sclk,
  output logic        afe_sdata,
  output logic        afe_sload,
  output logic        busy,
  output logic        cfg_done,
  output logic        scan_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  // Last count of a half period and of the double-length gap.
  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [8:0]  hc_q, hc_d;
  logic [3:0]  bc_q, bc_d;
  logic        ph_q, ph_d;
  logic [15:0] word_q, word_d;
  logic        is_cfg_q, is_cfg_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic        gain_valid_q, gain_valid_d;
  logic [8:0]  gain_shadow_q, gain_shadow_d;
  logic        off_valid_q, off_valid_d;
  logic [8:0]  off_shadow_q, off_shadow_d;
  logic        cfg_done_q, cfg_done_d;
  logic        scan_en_q, scan_en_d;
  logic        sclk_q, sclk_d;
  logic        sdata_q, sdata_d;
  logic        sload_q, sload_d;
  logic        busy_q, busy_d;

  logic        gain_pend;
  logic        off_pend;
  logic        hc_last;
  logic        start;

  // Only the low nine bits reach the AFE; the upper bits are deliberately dropped.
  logic unused_hi;
  assign unused_hi = ^{cont_gain[15:9], cont_off[15:9]};

  assign gain_pend = !gain_valid_q || (cont_gain[8:0] != gain_shadow_q);
  assign off_pend  = !off_valid_q  || (cont_off[8:0]  != off_shadow_q);
  assign hc_last   = (hc_q == HALF_LAST);

  // Next-state, frame selection and registered-output values.
  always_comb begin
    state_d       = state_q;
    hc_d          = hc_q;
    bc_d          = bc_q;
    ph_d          = ph_q;
    word_d        = word_q;
    is_cfg_d      = is_cfg_q;
    cfg_pend_d    = cfg_pend_q;
    gain_valid_d  = gain_valid_q;
    gain_shadow_d = gain_shadow_q;
    off_valid_d   = off_valid_q;
    off_shadow_d  = off_shadow_q;
    cfg_done_d    = cfg_done_q;
    start         = 1'b0;

    case (state_q)
      S_IDLE: begin
        start = 1'b1;
      end
      S_LOAD: begin
        if (hc_last) begin
          state_d = S_SHIFT;
          hc_d    = 9'd0;
          ph_d    = 1'b0;
          bc_d    = 4'd15;
        end else begin
          hc_d = hc_q + 9'd1;
        end
      end
      S_SHIFT: begin
        if (hc_last) begin
          hc_d = 9'd0;
          if (!ph_q) begin
            ph_d = 1'b1;
          end else if (bc_q == 4'd0) begin
            state_d = S_HOLD;
            ph_d    = 1'b0;
          end else begin
            bc_d = bc_q - 4'd1;
            ph_d = 1'b0;
          end
        end else begin
          hc_d = hc_q + 9'd1;
        end
      end
      S_HOLD: begin
        if (hc_last) begin
          state_d = S_GAP;
          hc_d    = 9'd0;
        end else begin
          hc_d = hc_q + 9'd1;
        end
      end
      S_GAP: begin
        if (hc_q == GAP_LAST) begin
          state_d = S_IDLE;
          hc_d    = 9'd0;
          start   = 1'b1;
          if (is_cfg_q) begin
            cfg_pend_d = 1'b0;
          end
          if (!cfg_pend_d && gain_valid_q && off_valid_q) begin
            cfg_done_d = 1'b1;
          end
        end else begin
          hc_d = hc_q + 9'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        hc_d    = 9'd0;
      end
    endcase

    // Leaving the gap passes through the idle decision in the same cycle,
    // so queued writes follow each other with no dead cycle.
    if (start && (cfg_pend_d || gain_pend || off_pend)) begin
      state_d = S_LOAD;
      hc_d    = 9'd0;
      bc_d    = 4'd15;
      ph_d    = 1'b0;
      if (cfg_pend_d) begin
        word_d   = {1'b0, CFG_ADDR, 3'b000, CFG_DATA};
        is_cfg_d = 1'b1;
      end else if (gain_pend) begin
        word_d        = {1'b0, GAIN_ADDR, 3'b000, cont_gain[8:0]};
        is_cfg_d      = 1'b0;
        gain_shadow_d = cont_gain[8:0];
        gain_valid_d  = 1'b1;
      end else begin
        word_d       = {1'b0, OFF_ADDR, 3'b000, cont_off[8:0]};
        is_cfg_d     = 1'b0;
        off_shadow_d = cont_off[8:0];
        off_valid_d  = 1'b1;
      end
    end

    sload_d = !((state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_HOLD));
    sclk_d  = (state_d == S_SHIFT) && ph_d;
    sdata_d = sdata_q;
    if ((state_d == S_LOAD) || (state_d == S_SHIFT)) begin
      sdata_d = word_d[bc_d];
    end
    busy_d    = (state_d != S_IDLE);
    scan_en_d = cont_en && cfg_done_q && !busy_q && !gain_pend && !off_pend;
  end

  // State, shadows and all output registers, with synchronous reset.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hc_q          <= 9'd0;
      bc_q          <= 4'd15;
      ph_q          <= 1'b0;
      word_q        <= 16'd0;
      is_cfg_q      <= 1'b0;
      cfg_pend_q    <= 1'b1;
      gain_valid_q  <= 1'b0;
      gain_shadow_q <= 9'd0;
      off_valid_q   <= 1'b0;
      off_shadow_q  <= 9'd0;
      cfg_done_q    <= 1'b0;
      scan_en_q     <= 1'b0;
      sclk_q        <= 1'b0;
      sdata_q       <= 1'b0;
      sload_q       <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hc_q          <= hc_d;
      bc_q          <= bc_d;
      ph_q          <= ph_d;
      word_q        <= word_d;
      is_cfg_q      <= is_cfg_d;
      cfg_pend_q    <= cfg_pend_d;
      gain_valid_q  <= gain_valid_d;
      gain_shadow_q <= gain_shadow_d;
      off_valid_q   <= off_valid_d;
      off_shadow_q  <= off_shadow_d;
      cfg_done_q    <= cfg_done_d;
      scan_en_q     <= scan_en_d;
      sclk_q        <= sclk_d;
      sdata_q       <= sdata_d;
      sload_q       <= sload_d;
      busy_q        <= busy_d;
    end
  end

  assign afe_sclk  = sclk_q;
  assign afe_sdata = sdata_q;
  assign afe_sload = sload_q;
  assign busy      = busy_q;
  assign cfg_done  = cfg_done_q;
  assign scan_en   = scan_en_q;

endmodule

// File: tb/tb_afe_config.sv
// tb/tb_afe_config.sv - directed bench for afe_config: frame capture, timing, pending and reset behaviour
`timescale 1ns/1ps
module tb_afe_config;

  logic        clk_100M = 1'b0;
  logic        rst = 1'b1;
  logic        cont_en = 1'b0;
  logic [15:0] cont_gain = 16'h0000;
  logic [15:0] cont_off = 16'h0000;
  logic        afe_sclk, afe_sdata, afe_sload, busy, cfg_done, scan_en;

  int errors = 0;
  int checks = 0;

  always #5 clk_100M = ~clk_100M;

  afe_config #(
    .CLK_DIV  (5),
    .CFG_ADDR (3'd0),
    .CFG_DATA (9'h0C8),
    .GAIN_ADDR(3'd2),
    .OFF_ADDR (3'd5)
  ) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .cont_en  (cont_en),
    .cont_gain(cont_gain),
    .cont_off (cont_off),
    .afe_sclk (afe_sclk),
    .afe_sdata(afe_sdata),
    .afe_sload(afe_sload),
    .busy     (busy),
    .cfg_done (cfg_done),
    .scan_en  (scan_en)
  );

  // Serial-port monitor: rebuilds each frame from the pins on the falling clock edge.
  int          cyc = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_sload = 1'b1;
  logic [15:0] cur_word = 16'h0;
  int          cur_edges = 0;
  int          cur_low = 0;
  int          stray = 0;
  logic [15:0] words[$];
  int          edges[$];
  int          lows[$];
  int          falls[$];

  always @(negedge clk_100M) begin
    cyc++;
    if (afe_sload === 1'b0) begin
      if (prev_sload === 1'b1) begin
        cur_word  = 16'h0;
        cur_edges = 0;
        cur_low   = 0;
        falls.push_back(cyc);
      end
      cur_low++;
      if (afe_sclk === 1'b1 && prev_sclk === 1'b0) begin
        cur_word = {cur_word[14:0], afe_sdata};
        cur_edges++;
      end
    end else begin
      if (afe_sclk === 1'b1 && prev_sclk === 1'b0) stray++;
      if (prev_sload === 1'b0 && afe_sload === 1'b1) begin
        words.push_back(cur_word);
        edges.push_back(cur_edges);
        lows.push_back(cur_low);
      end
    end
    prev_sclk  = afe_sclk;
    prev_sload = afe_sload;
  end

  task automatic tick();
    @(negedge clk_100M);
    #1;
  endtask

  task automatic flush();
    words.delete();
    edges.delete();
    lows.delete();
    falls.delete();
    stray = 0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (words.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_mid(input int edge_n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (afe_sload === 1'b0 && cur_edges == edge_n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (afe_sclk !== 1'b0)  begin errors++; $display("FAIL reset_sclk: got %b expected 0", afe_sclk); end
    checks++; if (afe_sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b expected 0", afe_sdata); end
    checks++; if (afe_sload !== 1'b1) begin errors++; $display("FAIL reset_sload: got %b expected 1", afe_sload); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cfg_done !== 1'b0)  begin errors++; $display("FAIL reset_cfg_done: got %b expected 0", cfg_done); end
    checks++; if (scan_en !== 1'b0)   begin errors++; $display("FAIL reset_scan_en: got %b expected 0", scan_en); end
  endtask

  task automatic test_init_sequence();
    logic [15:0] exp_w[3];
    int n;
    bit got;
    exp_w[0] = 16'h00C8;
    exp_w[1] = 16'h2021;
    exp_w[2] = 16'h5105;
    cont_gain = 16'h0021;
    cont_off  = 16'h0105;
    cont_en   = 1'b1;
    flush();
    rst = 1'b0;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      tick();
      n++;
      if (cfg_done === 1'b1) got = 1'b1;
    end
    // Cycle 0 is the first edge after release; cfg_done is visible after edge index 540.
    checks++;
    if (!got || (n - 1) != 540) begin
      errors++; $display("FAIL init_cfg_done_cycle: got %0d (seen=%0b) expected 540", n - 1, got);
    end
    checks++;
    if (words.size() != 3) begin errors++; $display("FAIL init_frame_count: got %0d expected 3", words.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < words.size()) begin
        checks++; if (words[i] !== exp_w[i]) begin errors++; $display("FAIL init_word%0d: got %h expected %h", i, words[i], exp_w[i]); end
        checks++; if (edges[i] != 16) begin errors++; $display("FAIL init_edges%0d: got %0d expected 16", i, edges[i]); end
        checks++; if (lows[i] != 170) begin errors++; $display("FAIL init_sload_low%0d: got %0d expected 170", i, lows[i]); end
      end
    end
    if (falls.size() >= 3) begin
      checks++; if (falls[1] - falls[0] != 180) begin errors++; $display("FAIL init_period01: got %0d expected 180", falls[1] - falls[0]); end
      checks++; if (falls[2] - falls[1] != 180) begin errors++; $display("FAIL init_period12: got %0d expected 180", falls[2] - falls[1]); end
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL init_stray_sclk: got %0d expected 0", stray); end
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin
      tick();
      if (scan_en === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL init_scan_en: got %b expected 1", scan_en); end
  endtask

  task automatic test_gain_change();
    bit ok;
    int n;
    checks++; if (scan_en !== 1'b1) begin errors++; $display("FAIL gain_pre_scan_en: got %b expected 1", scan_en); end
    flush();
    cont_gain = 16'h003F;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 2 && !ok; i++) begin
      tick();
      n++;
      if (scan_en === 1'b0) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL gain_scan_drop: got %b expected 0 within 2 cycles", scan_en); end
    wait_frames(1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gain_frame_timeout: got %0d frames expected 1", words.size()); end
    if (ok) begin
      checks++; if (words[0] !== 16'h203F) begin errors++; $display("FAIL gain_word: got %h expected 203f", words[0]); end
      checks++; if (edges[0] != 16) begin errors++; $display("FAIL gain_edges: got %0d expected 16", edges[0]); end
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (scan_en === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL gain_scan_return: got %b expected 1", scan_en); end
    checks++; if (words.size() != 1) begin errors++; $display("FAIL gain_frame_count: got %0d expected 1", words.size()); end
  endtask

  task automatic test_gain_mid_frame();
    bit ok;
    flush();
    cont_gain = 16'h0010;
    // Ninth rising edge belongs to bit 7.
    wait_mid(9, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach_bit7: got edges=%0d expected 9", cur_edges); end
    cont_gain = 16'h0011;
    wait_frames(2, 800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_frame_timeout: got %0d frames expected 2", words.size()); end
    if (ok) begin
      checks++; if (words[0] !== 16'h2010) begin errors++; $display("FAIL mid_word0: got %h expected 2010", words[0]); end
      checks++; if (words[1] !== 16'h2011) begin errors++; $display("FAIL mid_word1: got %h expected 2011", words[1]); end
      checks++; if (falls[1] - falls[0] != 180) begin errors++; $display("FAIL mid_back_to_back: got %0d expected 180", falls[1] - falls[0]); end
    end
    wait_idle(400, ok);
    repeat (200) tick();
    checks++; if (words.size() != 2) begin errors++; $display("FAIL mid_frame_count: got %0d expected 2", words.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_idle(400, ok);
    flush();
    cont_gain = 16'h0021;
    cont_off  = 16'h0107;
    wait_frames(2, 800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d frames expected 2", words.size()); end
    if (ok) begin
      checks++; if (words[0] !== 16'h2021) begin errors++; $display("FAIL b2b_word0: got %h expected 2021", words[0]); end
      checks++; if (words[1] !== 16'h5107) begin errors++; $display("FAIL b2b_word1: got %h expected 5107", words[1]); end
      checks++; if (falls[1] - falls[0] != 180) begin errors++; $display("FAIL b2b_period: got %0d expected 180", falls[1] - falls[0]); end
    end
    wait_idle(400, ok);
    repeat (300) tick();
    checks++; if (words.size() != 2) begin errors++; $display("FAIL b2b_frame_count: got %0d expected 2", words.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    wait_idle(400, ok);
    flush();
    cont_off = 16'h0105;
    // Seventh rising edge belongs to bit 9.
    wait_mid(7, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_bit9: got edges=%0d expected 7", cur_edges); end
    rst = 1'b1;
    tick();
    checks++; if (afe_sload !== 1'b1) begin errors++; $display("FAIL rstmid_sload: got %b expected 1", afe_sload); end
    checks++; if (afe_sclk !== 1'b0)  begin errors++; $display("FAIL rstmid_sclk: got %b expected 0", afe_sclk); end
    checks++; if (cfg_done !== 1'b0)  begin errors++; $display("FAIL rstmid_cfg_done: got %b expected 0", cfg_done); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    rst = 1'b0;
    flush();
    wait_frames(3, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: got %0d frames expected 3", words.size()); end
    if (ok) begin
      checks++; if (words[0] !== 16'h00C8) begin errors++; $display("FAIL rstmid_word0: got %h expected 00c8", words[0]); end
      checks++; if (words[1] !== 16'h2021) begin errors++; $display("FAIL rstmid_word1: got %h expected 2021", words[1]); end
      checks++; if (words[2] !== 16'h5105) begin errors++; $display("FAIL rstmid_word2: got %h expected 5105", words[2]); end
    end
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (scan_en === 1'b1 && cfg_done === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_ready: got cfg_done=%b scan_en=%b expected 1/1", cfg_done, scan_en); end
  endtask

  task automatic test_high_bits_ignored();
    int busy_seen;
    int scan_low;
    flush();
    cont_off = 16'hFF05;
    busy_seen = 0;
    scan_low = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
      if (scan_en !== 1'b1) scan_low++;
    end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL hibits_busy: got %0d busy cycles expected 0", busy_seen); end
    checks++; if (scan_low != 0)  begin errors++; $display("FAIL hibits_scan_en: got %0d low cycles expected 0", scan_low); end
    checks++; if (words.size() != 0) begin errors++; $display("FAIL hibits_frames: got %0d expected 0", words.size()); end
    checks++; if (stray != 0) begin errors++; $display("FAIL hibits_stray_sclk: got %0d expected 0", stray); end
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_gain_change();
    test_gain_mid_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_high_bits_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
